// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing front end for a VGA output path. A free-running h/v counter
//   pair defines the raster. The registered counts go to an external draw
//   stage, which returns a pixel PIPE_DLY clocks later. Sync and active-area
//   flags decoded from the counts are delayed so that they line up with that
//   returning pixel. The pixel is blanked outside the active area and
//   registered together with the syncs.
//
// Ports
//   clk_25      in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   h_count     out  [9:0] horizontal raster position (registered)
//   v_count     out  [9:0] vertical raster position (registered)
//   frame_tick  out  one-clock pulse at raster position (0,0)
//   rgb_in      in   [7:0] pixel from the draw stage, PIPE_DLY clocks after its counts
//   rgb_out     out  [7:0] blanked pixel (registered)
//   hsync       out  active-low horizontal sync, aligned to rgb_out
//   vsync       out  active-low vertical sync, aligned to rgb_out
//   video_on    out  active-area flag, aligned to rgb_out
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 521,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 31,
  parameter int V_ACT_END   = 511,
  parameter int PIPE_DLY    = 1
) (
  input  logic       clk_25,
  input  logic       rst_n,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       frame_tick,
  input  logic [7:0] rgb_in,
  output logic [7:0] rgb_out,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on
);

  // Compare in 11 bits so that an END/TOTAL bound of exactly 1024 still works.
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_B  = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_S_B = 11'(H_ACT_START);
  localparam logic [10:0] H_ACT_E_B = 11'(H_ACT_END);
  localparam logic [10:0] V_SYNC_B  = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_S_B = 11'(V_ACT_START);
  localparam logic [10:0] V_ACT_E_B = 11'(V_ACT_END);

  // Reject geometries that the decode below cannot represent.
  if (!(H_SYNC < H_ACT_START && H_ACT_START < H_ACT_END &&
        H_ACT_END <= H_TOTAL && H_TOTAL <= 1024 &&
        V_SYNC < V_ACT_START && V_ACT_START < V_ACT_END &&
        V_ACT_END <= V_TOTAL && V_TOTAL <= 1024 &&
        PIPE_DLY >= 1 && PIPE_DLY <= 4)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  // Half-open window test [lo, hi) on an unsigned count.
  function automatic logic in_window(input logic [9:0]  cnt,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, cnt} >= lo) && ({1'b0, cnt} < hi);
  endfunction

  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;
  logic       h_wrap;

  // Stage 0: raster counters
  always_comb begin
    h_wrap    = (h_count_q == H_LAST);
    h_count_d = h_wrap ? 10'd0 : h_count_q + 10'd1;
    v_count_d = v_count_q;
    if (h_wrap) begin
      v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_count_q <= 10'd0;
      v_count_q <= 10'd0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  // Decoded straight from the registered counts, so it cannot glitch.
  // It also reads 1 while reset holds the counts at (0,0).
  assign frame_tick = (h_count_q == 10'd0) && (v_count_q == 10'd0);

  logic hs_raw, vs_raw, act_raw;

  always_comb begin
    hs_raw  = ({1'b0, h_count_q} >= H_SYNC_B);
    vs_raw  = ({1'b0, v_count_q} >= V_SYNC_B);
    act_raw = in_window(h_count_q, H_ACT_S_B, H_ACT_E_B) &&
              in_window(v_count_q, V_ACT_S_B, V_ACT_E_B);
  end

  // Stage 1..PIPE_DLY+1: delay lines. Bit k holds the raw decode from k+1
  // clocks ago. Bit PIPE_DLY-1 lines up with rgb_in and gates the pixel
  // register. Bit PIPE_DLY lines up with rgb_out.
  logic [PIPE_DLY:0] hs_dly_q, hs_dly_d;
  logic [PIPE_DLY:0] vs_dly_q, vs_dly_d;
  logic [PIPE_DLY:0] act_dly_q, act_dly_d;
  logic [7:0]        rgb_q, rgb_d;

  always_comb begin
    hs_dly_d  = {hs_dly_q[PIPE_DLY-1:0], hs_raw};
    vs_dly_d  = {vs_dly_q[PIPE_DLY-1:0], vs_raw};
    act_dly_d = {act_dly_q[PIPE_DLY-1:0], act_raw};
    rgb_d     = act_dly_q[PIPE_DLY-1] ? rgb_in : 8'h00;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      hs_dly_q  <= '1;
      vs_dly_q  <= '1;
      act_dly_q <= '0;
      rgb_q     <= 8'h00;
    end else begin
      hs_dly_q  <= hs_dly_d;
      vs_dly_q  <= vs_dly_d;
      act_dly_q <= act_dly_d;
      rgb_q     <= rgb_d;
    end
  end

  assign h_count  = h_count_q;
  assign v_count  = v_count_q;
  assign rgb_out  = rgb_q;
  assign hsync    = hs_dly_q[PIPE_DLY];
  assign vsync    = vs_dly_q[PIPE_DLY];
  assign video_on = act_dly_q[PIPE_DLY];

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps

module tb_vga_timing_gen;

  logic clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  logic rst_n;

  // Full-size 640x480 instance; the draw stage is modelled as a register of h_count[7:0].
  logic [9:0] h_count, v_count;
  logic       frame_tick, hsync, vsync, video_on;
  logic [7:0] rgb_in = 8'h00;
  logic [7:0] rgb_out;

  always @(posedge clk_25) rgb_in <= h_count[7:0];

  vga_timing_gen dut (
    .clk_25(clk_25), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
    .frame_tick(frame_tick), .rgb_in(rgb_in), .rgb_out(rgb_out),
    .hsync(hsync), .vsync(vsync), .video_on(video_on)
  );

  // Small-geometry instance (20x12 raster, 12x6 active, PIPE_DLY=2) for whole-frame checks.
  logic [9:0] s_h, s_v;
  logic       s_ft, s_hs, s_vs, s_vo;
  logic [7:0] s_rgb_in;
  logic [7:0] s_rgb_out;

  vga_timing_gen #(
    .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
    .V_TOTAL(12), .V_SYNC(2), .V_ACT_START(4), .V_ACT_END(10), .PIPE_DLY(2)
  ) dut_s (
    .clk_25(clk_25), .rst_n(rst_n), .h_count(s_h), .v_count(s_v),
    .frame_tick(s_ft), .rgb_in(s_rgb_in), .rgb_out(s_rgb_out),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vo)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int         n;
    logic [9:0] h;
    logic [9:0] v;
    logic       ft;
    logic       hs;
    logic       vs;
    logic       vo;
    logic [7:0] rgb;
  } vec_t;

  localparam int NVEC = 17;
  localparam int NRUN = 25600;
  vec_t vecs[NVEC];

  // Running-state trackers
  int ph, pv, sph, spv;
  int m_hs_prev, m_hs_low, m_hs_fall, m_vs_prev, m_vs_low, m_ft_cnt;
  int s_hs_prev, s_hs_low, s_hs_fall, s_vs_prev, s_vs_low, s_vs_fall;
  int s_ft_last, s_ft_cnt, s_win, s_vmax, vi;
  int found;

  initial begin
    // n = rising edges since reset release; expected values hand-derived
    // (outputs at n reflect raw decode at n-2, rgb_out = h(n-2)[7:0] when active).
    vecs[0]  = '{0,     10'd0,   10'd0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1,     10'd1,   10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{2,     10'd2,   10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{97,    10'd97,  10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{98,    10'd98,  10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{799,   10'd799, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{800,   10'd0,   10'd1,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{801,   10'd1,   10'd1,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{802,   10'd2,   10'd1,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1600,  10'd0,   10'd2,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1602,  10'd2,   10'd2,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{24202, 10'd202, 10'd30, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[12] = '{24945, 10'd145, 10'd31, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[13] = '{24946, 10'd146, 10'd31, 1'b0, 1'b1, 1'b1, 1'b1, 8'h90};
    vecs[14] = '{24947, 10'd147, 10'd31, 1'b0, 1'b1, 1'b1, 1'b1, 8'h91};
    vecs[15] = '{25585, 10'd785, 10'd31, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0F};
    vecs[16] = '{25586, 10'd786, 10'd31, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

    rst_n    = 1'b0;
    s_rgb_in = 8'hA5;
    repeat (3) @(negedge clk_25);

    // Values held during reset, with the clock running
    chk("rst_h", h_count, 0);       chk("rst_v", v_count, 0);
    chk("rst_ft", frame_tick, 1);   chk("rst_hs", hsync, 1);
    chk("rst_vs", vsync, 1);        chk("rst_vo", video_on, 0);
    chk("rst_rgb", rgb_out, 0);
    chk("s_rst_hs", s_hs, 1);       chk("s_rst_vs", s_vs, 1);
    chk("s_rst_rgb", s_rgb_out, 0); chk("s_rst_ft", s_ft, 1);

    rst_n = 1'b1;
    ph = 0; pv = 0; sph = 0; spv = 0; vi = 0;
    m_hs_prev = 1; m_hs_low = 0; m_hs_fall = -1; m_vs_prev = 1; m_vs_low = 0; m_ft_cnt = 0;
    s_hs_prev = 1; s_hs_low = 0; s_hs_fall = -1; s_vs_prev = 1; s_vs_low = 0; s_vs_fall = -1;
    s_ft_last = -1; s_ft_cnt = 0; s_win = 0; s_vmax = 0;

    for (int n = 0; n <= NRUN; n++) begin
      // Directed vector table
      if (vi < NVEC && vecs[vi].n == n) begin
        chk($sformatf("vec%0d_h", vi),   h_count,    vecs[vi].h);
        chk($sformatf("vec%0d_v", vi),   v_count,    vecs[vi].v);
        chk($sformatf("vec%0d_ft", vi),  frame_tick, vecs[vi].ft);
        chk($sformatf("vec%0d_hs", vi),  hsync,      vecs[vi].hs);
        chk($sformatf("vec%0d_vs", vi),  vsync,      vecs[vi].vs);
        chk($sformatf("vec%0d_vo", vi),  video_on,   vecs[vi].vo);
        chk($sformatf("vec%0d_rgb", vi), rgb_out,    vecs[vi].rgb);
        vi++;
      end

      // Counter sequence: h wraps at 799, v advances only on that wrap
      if (n > 0) begin
        chk($sformatf("h_seq@%0d", n), h_count, (ph == 799) ? 0 : ph + 1);
        chk($sformatf("v_seq@%0d", n), v_count, (ph == 799) ? pv + 1 : pv);
        chk($sformatf("s_h_seq@%0d", n), s_h, (sph == 19) ? 0 : sph + 1);
        chk($sformatf("s_v_seq@%0d", n), s_v,
            (sph == 19) ? ((spv == 11) ? 0 : spv + 1) : spv);
      end
      ph = h_count; pv = v_count; sph = s_h; spv = s_v;
      if (s_v > s_vmax) s_vmax = s_v;
      if (frame_tick) m_ft_cnt++;

      // Full-size hsync: 96 low, 800 period; vsync: 1600 low
      if (!hsync) begin
        if (m_hs_prev == 1) begin
          if (m_hs_fall >= 0) chk("hs_period", n - m_hs_fall, 800);
          m_hs_fall = n; m_hs_low = 0;
        end
        m_hs_low++;
      end else if (m_hs_prev == 0) chk("hs_low_width", m_hs_low, 96);
      m_hs_prev = hsync;
      if (!vsync) m_vs_low++;
      else if (m_vs_prev == 0) chk("vs_low_width", m_vs_low, 1600);
      m_vs_prev = vsync;

      // Small instance: hsync 3 low / 20 period, vsync 40 low / 240 period
      if (!s_hs) begin
        if (s_hs_prev == 1) begin
          if (s_hs_fall >= 0) chk("s_hs_period", n - s_hs_fall, 20);
          s_hs_fall = n; s_hs_low = 0;
        end
        s_hs_low++;
      end else if (s_hs_prev == 0) chk("s_hs_low_width", s_hs_low, 3);
      s_hs_prev = s_hs;
      if (!s_vs) begin
        if (s_vs_prev == 1) begin
          if (s_vs_fall >= 0) chk("s_vs_period", n - s_vs_fall, 240);
          s_vs_fall = n; s_vs_low = 0;
        end
        s_vs_low++;
      end else if (s_vs_prev == 0) chk("s_vs_low_width", s_vs_low, 40);
      s_vs_prev = s_vs;

      // Small instance: one tick per 240 clocks, blanking and 72 lit pixels per frame
      if (s_ft) begin
        if (s_ft_last >= 0) chk("s_ft_period", n - s_ft_last, 240);
        s_ft_last = n; s_ft_cnt++;
      end
      chk($sformatf("s_blank@%0d", n), s_rgb_out, s_vo ? 8'hA5 : 8'h00);
      if (s_rgb_out == 8'hA5) s_win++;
      if (n % 240 == 239) begin
        chk($sformatf("s_active_px@%0d", n), s_win, 72);
        s_win = 0;
      end

      @(negedge clk_25);
    end

    chk("m_ft_count", m_ft_cnt, 1);
    chk("s_ft_count", s_ft_cnt, 107);
    chk("s_vmax", s_vmax, 11);

    // Mid-frame reset at (400,32): clears asynchronously within the low clock phase
    found = 0;
    for (int k = 0; k < 2000; k++) begin
      if (h_count == 10'd400 && v_count == 10'd32) begin
        found = 1;
        break;
      end
      @(negedge clk_25);
    end
    chk("reach_400_32", found, 1);
    chk("pre_rst_vo", video_on, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_h", h_count, 0);    chk("arst_v", v_count, 0);
    chk("arst_hs", hsync, 1);     chk("arst_vs", vsync, 1);
    chk("arst_vo", video_on, 0);  chk("arst_rgb", rgb_out, 0);
    chk("arst_ft", frame_tick, 1);
    chk("s_arst_h", s_h, 0);
    repeat (3) @(negedge clk_25);
    rst_n = 1'b1;

    // After release: timing restarts at (0,0); hsync first low at n=2, full 96-wide pulses
    for (int n = 0; n <= 1700; n++) begin
      if (n == 0) begin
        chk("rel_h", h_count, 0); chk("rel_v", v_count, 0); chk("rel_ft", frame_tick, 1);
      end
      chk($sformatf("rel_hs@%0d", n), hsync, (n < 2) ? 1 : (((n - 2) % 800) >= 96));
      chk($sformatf("rel_vs@%0d", n), vsync, (n < 2 || n >= 1602) ? 1 : 0);
      chk($sformatf("rel_rgb@%0d", n), rgb_out, 0);
      @(negedge clk_25);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
